// File: rtl/ex_mem_buffer_pkg.sv
// Shared definitions for the EX/MEM stage buffer and its neighbouring stage buffers.
package ex_mem_buffer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] RST_VAL = '0;

  // The six EX/MEM fields as one bundle, in pipeline lane order.
  typedef struct packed {
    logic [DATA_W-1:0] write_back_ctrl;
    logic [DATA_W-1:0] memory_ctrl;
    logic [DATA_W-1:0] alu_result_top;
    logic [DATA_W-1:0] alu_result_bottom;
    logic [DATA_W-1:0] sign_ext;
    logic [DATA_W-1:0] inst;
  } ex_mem_fields_t;

endpackage

// File: rtl/ex_mem_buffer_pipe_reg.sv
// Single pipeline lane: WIDTH-bit register, async active-low clear, active-high hold.
module pipe_reg
  import ex_mem_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear on reset, otherwise load unless the pipeline is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= WIDTH'(RST_VAL);
    end else if (!halt) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline register: six independent lanes sharing clock, reset and stall.
module ex_mem_buffer
  import ex_mem_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic [WIDTH-1:0] write_back_ctrl_sgnl,
  input  logic [WIDTH-1:0] memory_ctrl_sgnl,
  input  logic [WIDTH-1:0] alu_result_top_half,
  input  logic [WIDTH-1:0] alu_result_bottom_half,
  input  logic [WIDTH-1:0] sign_ext_buff_in,
  input  logic [WIDTH-1:0] inst_buff_in,
  output logic [WIDTH-1:0] write_back_ctrl_sgnl_out,
  output logic [WIDTH-1:0] memory_ctrl_sgnl_out,
  output logic [WIDTH-1:0] alu_result_top_half_out,
  output logic [WIDTH-1:0] alu_result_bottom_half_out,
  output logic [WIDTH-1:0] sign_ext_buff_out,
  output logic [WIDTH-1:0] inst_buff_out
);

  pipe_reg #(.WIDTH(WIDTH)) u_wb_reg (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .d    (write_back_ctrl_sgnl),
    .q    (write_back_ctrl_sgnl_out)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_mem_reg (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .d    (memory_ctrl_sgnl),
    .q    (memory_ctrl_sgnl_out)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_alu_top_reg (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .d    (alu_result_top_half),
    .q    (alu_result_top_half_out)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_alu_bottom_reg (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .d    (alu_result_bottom_half),
    .q    (alu_result_bottom_half_out)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_sext_reg (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .d    (sign_ext_buff_in),
    .q    (sign_ext_buff_out)
  );

  pipe_reg #(.WIDTH(WIDTH)) u_inst_reg (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .d    (inst_buff_in),
    .q    (inst_buff_out)
  );

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Self-checking bench for ex_mem_buffer: directed scenarios plus randomized run against a lane model.
module tb_ex_mem_buffer;

  localparam int unsigned W = 16;
  localparam int unsigned NL = 6;

  logic         clk;
  logic         rst;
  logic         halt;
  logic [W-1:0] din  [NL];
  logic [W-1:0] dout [NL];
  logic [W-1:0] model [NL];

  int compared;
  int mismatched;

  ex_mem_buffer #(.WIDTH(W)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .halt                       (halt),
    .write_back_ctrl_sgnl       (din[0]),
    .memory_ctrl_sgnl           (din[1]),
    .alu_result_top_half        (din[2]),
    .alu_result_bottom_half     (din[3]),
    .sign_ext_buff_in           (din[4]),
    .inst_buff_in               (din[5]),
    .write_back_ctrl_sgnl_out   (dout[0]),
    .memory_ctrl_sgnl_out       (dout[1]),
    .alu_result_top_half_out    (dout[2]),
    .alu_result_bottom_half_out (dout[3]),
    .sign_ext_buff_out          (dout[4]),
    .inst_buff_out              (dout[5])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_inputs(input logic [W-1:0] v0, v1, v2, v3, v4, v5);
    din[0] = v0; din[1] = v1; din[2] = v2;
    din[3] = v3; din[4] = v4; din[5] = v5;
  endtask

  task automatic set_random_inputs();
    for (int i = 0; i < NL; i++) din[i] = W'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    halt = 1'b0;
    for (int e = 0; e < 3; e++) begin
      set_random_inputs();
      tick();
      for (int i = 0; i < NL; i++) begin
        compared++;
        if (dout[i] !== 16'h0000) begin
          mismatched++;
          $display("FAIL reset_hold lane %0d edge %0d: got %h want 0000", i, e, dout[i]);
        end
      end
    end
  endtask

  task automatic test_release_halt();
    rst = 1'b1;
    halt = 1'b1;
    set_inputs(16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd, 16'heeee, 16'hffff);
    for (int e = 0; e < 2; e++) begin
      tick();
      for (int i = 0; i < NL; i++) begin
        compared++;
        if (dout[i] !== 16'h0000) begin
          mismatched++;
          $display("FAIL release_halt lane %0d edge %0d: got %h want 0000", i, e, dout[i]);
        end
      end
    end
  endtask

  task automatic test_load();
    logic [W-1:0] exp_v [NL];
    exp_v = '{16'hffff, 16'heeee, 16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa};
    halt = 1'b0;
    set_inputs(exp_v[0], exp_v[1], exp_v[2], exp_v[3], exp_v[4], exp_v[5]);
    tick();
    for (int i = 0; i < NL; i++) begin
      compared++;
      if (dout[i] !== exp_v[i]) begin
        mismatched++;
        $display("FAIL load lane %0d: got %h want %h", i, dout[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] held [NL];
    logic [W-1:0] nxt  [NL];
    held = '{16'hffff, 16'heeee, 16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa};
    nxt  = '{16'h1234, 16'h4561, 16'h7894, 16'h5555, 16'h6523, 16'h1598};
    halt = 1'b1;
    tick();
    set_inputs(nxt[0], nxt[1], nxt[2], nxt[3], nxt[4], nxt[5]);
    #1;
    for (int i = 0; i < NL; i++) begin
      compared++;
      if (dout[i] !== held[i]) begin
        mismatched++;
        $display("FAIL no_comb_path lane %0d: got %h want %h", i, dout[i], held[i]);
      end
    end
    for (int e = 0; e < 4; e++) begin
      tick();
      for (int i = 0; i < NL; i++) begin
        compared++;
        if (dout[i] !== held[i]) begin
          mismatched++;
          $display("FAIL stall lane %0d edge %0d: got %h want %h", i, e, dout[i], held[i]);
        end
      end
    end
    halt = 1'b0;
    tick();
    for (int i = 0; i < NL; i++) begin
      compared++;
      if (dout[i] !== nxt[i]) begin
        mismatched++;
        $display("FAIL stall_release lane %0d: got %h want %h", i, dout[i], nxt[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] v [NL];
    v = '{16'h0f0f, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    // Outputs currently hold the stall-release values; drop reset mid-cycle.
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NL; i++) begin
      compared++;
      if (dout[i] !== 16'h0000) begin
        mismatched++;
        $display("FAIL async_reset lane %0d: got %h want 0000", i, dout[i]);
      end
    end
    tick();
    rst = 1'b1;
    halt = 1'b0;
    set_inputs(v[0], v[1], v[2], v[3], v[4], v[5]);
    tick();
    for (int i = 0; i < NL; i++) begin
      compared++;
      if (dout[i] !== v[i]) begin
        mismatched++;
        $display("FAIL post_reset_load lane %0d: got %h want %h", i, dout[i], v[i]);
      end
    end
    // Halt held high at edges, dropped briefly between them with new data present.
    halt = 1'b1;
    set_random_inputs();
    #2;
    halt = 1'b0;
    #2;
    halt = 1'b1;
    tick();
    for (int i = 0; i < NL; i++) begin
      compared++;
      if (dout[i] !== v[i]) begin
        mismatched++;
        $display("FAIL halt_glitch lane %0d: got %h want %h", i, dout[i], v[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NL; i++) model[i] = dout[i];
    for (int c = 0; c < 300; c++) begin
      set_random_inputs();
      halt = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b0;
        for (int i = 0; i < NL; i++) model[i] = '0;
        #1;
        for (int i = 0; i < NL; i++) begin
          compared++;
          if (dout[i] !== model[i]) begin
            mismatched++;
            $display("FAIL random_async lane %0d cycle %0d: got %h want %h", i, c, dout[i], model[i]);
          end
        end
      end else begin
        rst = 1'b1;
      end
      @(posedge clk);
      if (!rst) begin
        for (int i = 0; i < NL; i++) model[i] = '0;
      end else if (!halt) begin
        for (int i = 0; i < NL; i++) model[i] = din[i];
      end
      #1;
      for (int i = 0; i < NL; i++) begin
        compared++;
        if (dout[i] !== model[i]) begin
          mismatched++;
          $display("FAIL random lane %0d cycle %0d: got %h want %h", i, c, dout[i], model[i]);
        end
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    halt = 1'b0;
    for (int i = 0; i < NL; i++) din[i] = '0;
    #1;
    test_reset();
    test_release_halt();
    test_load();
    test_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_mem_buffer.md
# ex_mem_buffer

EX/MEM pipeline register of the 16-bit datapath. On each rising clock edge it captures the execute-stage results (write-back control, memory control, 32-bit ALU result split into two halves, sign-extended immediate, instruction word) and presents them to the memory stage. A `halt` input freezes all fields for pipeline stalls, and an asynchronous active-low reset clears every field.

## Interface
Parameters:
- `WIDTH`, default 16: width of every data/control lane.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low; `rst=0` clears all outputs.
- `halt`  in  1  active-high stall; 1 holds all registered outputs.
- `write_back_ctrl_sgnl`  in  WIDTH  write-back stage control bits.
- `memory_ctrl_sgnl`  in  WIDTH  memory stage control bits.
- `alu_result_top_half`  in  WIDTH  ALU result bits [31:16].
- `alu_result_bottom_half`  in  WIDTH  ALU result bits [15:0].
- `sign_ext_buff_in`  in  WIDTH  sign-extended immediate.
- `inst_buff_in`  in  WIDTH  instruction word.
- `write_back_ctrl_sgnl_out`  out  WIDTH  registered `write_back_ctrl_sgnl`.
- `memory_ctrl_sgnl_out`  out  WIDTH  registered `memory_ctrl_sgnl`.
- `alu_result_top_half_out`  out  WIDTH  registered `alu_result_top_half`.
- `alu_result_bottom_half_out`  out  WIDTH  registered `alu_result_bottom_half`.
- `sign_ext_buff_out`  out  WIDTH  registered `sign_ext_buff_in`.
- `inst_buff_out`  out  WIDTH  registered `inst_buff_in`.

## Operation
- Six independent WIDTH-bit registers, one per input/output pair; no field is transformed, combined or reordered.
- `rst=0`: all six outputs go to 0 immediately, whatever `clk`, `halt` or the data inputs are doing.
- `rst=1`, `halt=0`: on each rising edge every output register loads its input.
- `rst=1`, `halt=1`: on each rising edge every output register keeps its current value. Input changes have no effect.
- Priority: reset first, then halt, then load.
- `halt` freezes all six lanes together. There is no per-field enable.
- There is no flush/bubble input. Bubbles are inserted upstream by zeroing control inputs.

## Timing
- Latency: 1 cycle. An input sampled at edge N is visible on the output after edge N and holds until the next loading edge.
- Outputs come straight from flops, with no combinational path from any input to any output.
- Reset values: all outputs 16'h0000.
- `halt` is sampled at the rising edge only. A pulse between edges has no effect.
- Reset asserted mid-operation clears the outputs asynchronously. After reset deasserts, the first rising edge with `halt=0` loads the inputs.
- Reset deasserted with `halt=1`: outputs stay 0 until the first edge with `halt=0`.
- Outputs stay stable across any number of consecutive halted cycles.

## Structure
- Shared package: `DATA_W = 16`, `RST_VAL = '0`, and optionally a packed struct of the six EX/MEM fields reused by the neighbouring stage buffers.
- One sub-module: `pipe_reg`, a WIDTH-parameterised register with async active-low reset and active-high hold.
- Top level instantiates `pipe_reg` six times with a shared `clk`, `rst` and `halt`.

## Test plan
- Reset hold: `rst=0`, inputs arbitrary, several edges -> all outputs 0000.
- Release under halt: `rst=1`, `halt=1`, inputs aaaa/bbbb/cccc/dddd/eeee/ffff (WB, MEM, ALU-top, ALU-bottom, SEXT, INST), two edges -> outputs remain 0000.
- Load: `halt=0`, inputs ffff/eeee/dddd/cccc/bbbb/aaaa -> after the next edge, outputs ffff/eeee/dddd/cccc/bbbb/aaaa in the same lane order. The distinct per-lane values catch swapped wiring.
- Stall: `halt=1`, then inputs change to 1234/4561/7894/5555/6523/1598 -> outputs stay ffff/eeee/dddd/cccc/bbbb/aaaa for every halted edge. Releasing `halt` loads 1234/4561/7894/5555/6523/1598 one edge later.
- Async reset mid-operation: with outputs non-zero, drop `rst` between clock edges -> all outputs 0000 before the next edge. A glitch on `halt` between edges does not change the outputs.
